// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter and its companion receiver.
package uart_pkg;

   localparam int   uart_data_bits       = 8;
   localparam logic uart_start_bit       = 1'b0;
   localparam logic uart_stop_bit        = 1'b1;
   localparam int   uart_base_frame_bits = 10;

   typedef enum logic [1:0] {
      tx_idle,
      tx_busy,
      tx_last
   } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with optional extra stop bits and a req/cts byte handshake.
//
// state   | meaning
// tx_idle | remaining == 0, line held high, byte may be accepted
// tx_busy | frame in progress, requests ignored
// tx_last | final clock of the last stop bit, accept chains a new frame gaplessly
module uart_tx
   import uart_pkg::*;
#(
   parameter int clocks_per_bit  = 4,
   parameter int extra_stop_bits = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [uart_data_bits-1:0] i_data,
   input  logic                      i_req,
   output logic                      o_serial,
   output logic                      o_cts,
   output logic                      o_idle
);

   localparam int frame_bits = uart_base_frame_bits + extra_stop_bits;
   localparam int rem_w      = $clog2(frame_bits + 1);
   localparam int cyc_w      = $clog2(clocks_per_bit);

   localparam logic [rem_w-1:0] rem_load = rem_w'(frame_bits);
   localparam logic [rem_w-1:0] rem_one  = rem_w'(1);
   localparam logic [cyc_w-1:0] cyc_load = cyc_w'(clocks_per_bit - 1);
   localparam logic [cyc_w-1:0] cyc_one  = cyc_w'(1);

   logic [uart_data_bits:0] shift, shift_nxt;
   logic [rem_w-1:0]        remaining, remaining_nxt;
   logic [cyc_w-1:0]        cycle, cycle_nxt;
   tx_state_e               state;
   logic                    accept;

   // State is decoded from the counters so outputs never depend on inputs.
   always_comb begin
      state = tx_busy;
      if (remaining == '0) begin
         state = tx_idle;
      end else if (remaining == rem_one && cycle == '0) begin
         state = tx_last;
      end
   end

   assign o_idle   = (state == tx_idle);
   assign o_cts    = (state == tx_idle) || (state == tx_last);
   assign o_serial = (state == tx_idle) ? uart_stop_bit : shift[0];
   assign accept   = i_req && o_cts;

   always_comb begin
      shift_nxt     = shift;
      remaining_nxt = remaining;
      cycle_nxt     = cycle;
      if (accept) begin
         shift_nxt     = {i_data, uart_start_bit};
         remaining_nxt = rem_load;
         cycle_nxt     = cyc_load;
      end else if (state != tx_idle) begin
         if (cycle != '0) begin
            cycle_nxt = cycle - cyc_one;
         end else begin
            // Back-fill with stop level so the trailing stop bits need no extra logic.
            shift_nxt     = {uart_stop_bit, shift[uart_data_bits:1]};
            remaining_nxt = remaining - rem_one;
            cycle_nxt     = cyc_load;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift     <= '1;
         remaining <= '0;
         cycle     <= '0;
      end else begin
         shift     <= shift_nxt;
         remaining <= remaining_nxt;
         cycle     <= cycle_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: cycle-level line model plus a byte-level receiver monitor.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int XSTOP = 1;
   localparam int FRAME = 10 + XSTOP;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_data;
   logic       i_req;
   logic       o_serial, o_cts, o_idle;

   logic [7:0] d3_data;
   logic       d3_req;
   logic       d3_serial, d3_cts, d3_idle;

   int n_cmp  = 0;
   int n_fail = 0;

   bit         lvl_q[$];
   logic [7:0] exp_bytes[$];
   bit         acc_flag = 0;

   int run = 0, last_run = 0, cts_cnt = 0;

   bit         rx_busy = 0;
   int         rx_cnt  = 0;
   logic [7:0] rx_byte = '0;

   uart_tx #(.clocks_per_bit(CPB), .extra_stop_bits(XSTOP)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_req(i_req),
      .o_serial(o_serial), .o_cts(o_cts), .o_idle(o_idle)
   );

   uart_tx #(.clocks_per_bit(3), .extra_stop_bits(0)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .i_data(d3_data), .i_req(d3_req),
      .o_serial(d3_serial), .o_cts(d3_cts), .o_idle(d3_idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: each accepted byte appends its whole frame as a per-cycle level list.
   always @(negedge clk) begin
      bit exp_ser, exp_idle, exp_cts, acc;
      if (!rst_n) begin
         lvl_q.delete();
         exp_bytes.delete();
         acc_flag = 0;
         check("rst_serial", o_serial, 1);
         check("rst_idle", o_idle, 1);
      end else begin
         exp_idle = (lvl_q.size() == 0);
         exp_ser  = exp_idle ? 1'b1 : lvl_q[0];
         exp_cts  = (lvl_q.size() <= 1);
         check("line", o_serial, exp_ser);
         check("idle", o_idle, exp_idle);
         check("cts", o_cts, exp_cts);
         if (lvl_q.size() != 0) void'(lvl_q.pop_front());
         acc = i_req && exp_cts;
         acc_flag = acc;
         if (acc) begin
            exp_bytes.push_back(i_data);
            for (int b = 0; b < FRAME; b++) begin
               bit lvl;
               if (b == 0) lvl = 1'b0;
               else if (b <= 8) lvl = i_data[b-1];
               else lvl = 1'b1;
               for (int c = 0; c < CPB; c++) lvl_q.push_back(lvl);
            end
         end
      end
   end

   // Monitor: decode frames off the line like a receiver and pop the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         rx_busy = 0;
      end else if (!rx_busy) begin
         if (o_serial == 1'b0) begin
            rx_busy = 1;
            rx_cnt  = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            int bi;
            bi = rx_cnt / CPB;
            if (bi >= 1 && bi <= 8) rx_byte[bi-1] = o_serial;
            if (bi == 9) begin
               check("rx_stop", o_serial, 1);
               check("rx_expected", exp_bytes.size() != 0, 1);
               if (exp_bytes.size() != 0) check("rx_byte", rx_byte, exp_bytes.pop_front());
               rx_busy = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         run = 0;
      end else if (!o_idle) begin
         run++;
      end else begin
         if (run != 0) last_run = run;
         run = 0;
      end
      if (rst_n && o_cts && !o_idle) cts_cnt++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit hold);
      int t;
      i_req  = 1'b1;
      i_data = b;
      t = 0;
      do begin
         step(1);
         t++;
      end while (!acc_flag && t < 500);
      check("accept", acc_flag, 1);
      if (!hold) i_req = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!o_idle && t < 2000) begin
         step(1);
         t++;
      end
      check("idle_reached", o_idle, 1);
      step(1);
   endtask

   initial begin
      int base, low27, high3, cts_n, cts_at;
      rst_n = 1'b0; i_req = 1'b0; i_data = '0;
      d3_req = 1'b0; d3_data = '0;
      step(2);
      check("reset_serial", o_serial, 1);
      check("reset_cts", o_cts, 1);
      check("reset_idle", o_idle, 1);
      rst_n = 1'b1;
      step(3);

      send_byte(8'h55, 0);
      wait_idle();
      check("frame_len_55", last_run, FRAME * CPB);

      base = cts_cnt;
      send_byte(8'h48, 1);
      send_byte(8'h69, 0);
      wait_idle();
      check("b2b_idle_low", last_run, 2 * FRAME * CPB);
      check("b2b_cts_pulses", cts_cnt - base, 2);

      send_byte(8'h12, 0);
      step(8);
      i_req = 1'b1; i_data = 8'hFF;
      step(10);
      check("busy_ignores_req", o_idle, 0);
      i_req = 1'b0;
      wait_idle();
      check("frame_len_12", last_run, FRAME * CPB);

      send_byte(8'hA5, 0);
      step(17);
      #3;
      check("pre_reset_line", o_serial, 0);
      rst_n = 1'b0;
      #1;
      check("async_rst_serial", o_serial, 1);
      check("async_rst_cts", o_cts, 1);
      check("async_rst_idle", o_idle, 1);
      step(3);
      rst_n = 1'b1;
      step(2);
      send_byte(8'h3C, 0);
      wait_idle();
      check("frame_len_3c", last_run, FRAME * CPB);

      for (int k = 0; k < 30; k++) begin
         bit hold;
         hold = ($urandom_range(0, 1) == 1);
         send_byte(8'($urandom), hold);
         if (!hold) step($urandom_range(0, 50));
      end
      i_req = 1'b0;
      wait_idle();
      step(2);
      check("scoreboard_drained", exp_bytes.size(), 0);

      low27 = 0; high3 = 0; cts_n = 0; cts_at = 0;
      d3_req = 1'b1; d3_data = 8'h00;
      step(1);
      d3_req = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c <= 27 && d3_serial == 1'b0) low27++;
         if (c > 27 && d3_serial == 1'b1) high3++;
         if (d3_cts) begin
            cts_n++;
            cts_at = c;
         end
      end
      @(negedge clk);
      check("d3_low_cycles", low27, 27);
      check("d3_high_cycles", high3, 3);
      check("d3_cts_count", cts_n, 1);
      check("d3_cts_cycle", cts_at, 30);
      check("d3_idle_after", d3_idle, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter: accepts one 8-bit byte per request/clear-to-send handshake and drives it onto a single serial line as an 8N1 frame, with an optional number of extra stop bits. It sits between a byte-producing message source and the off-chip TX pin. It exposes `o_cts` (may accept a byte this cycle) and `o_idle` (line quiescent) so a source can wait for idle, then stream bytes back-to-back.

## Interface
Parameters:
- `clocks_per_bit`, default 4: clock cycles per serial bit; legal range ≥ 2.
- `extra_stop_bits`, default 0: stop bits beyond the mandatory one; legal range 0–7.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `i_data` in 8: byte to send; sampled only on an accept cycle.
- `i_req` in 1: source has a valid byte on `i_data`.
- `o_serial` out 1: TX line; idle-high.
- `o_cts` out 1: clear to send; a byte is accepted on any cycle with `i_req && o_cts`.
- `o_idle` out 1: no frame in progress.

## Operation
- Frame: start bit (0), data bits LSB first, one stop bit (1), then `extra_stop_bits` further 1s. Total `frame_bits = 10 + extra_stop_bits`.
- Registers:
  - `shift` (9 bits).
  - `remaining`: bits left in the frame; width `$clog2(frame_bits+1)`.
  - `cycle`: countdown within a bit; width `$clog2(clocks_per_bit)`.
- Accept:
  - `shift <= {i_data, 1'b0}`, `remaining <= frame_bits`, `cycle <= clocks_per_bit-1`.
  - Accept overrides the normal countdown update on the same edge.
- Countdown, while `remaining != 0` and no accept:
  - If `cycle != 0`, then `cycle <= cycle-1`.
  - Otherwise `shift <= {1'b1, shift[8:1]}`, `remaining <= remaining-1` and `cycle <= clocks_per_bit-1`.
- Outputs, all combinational from registers only, with no input-to-output paths:
  - `o_serial = (remaining == 0) ? 1 : shift[0]`.
  - `o_idle = (remaining == 0)`.
  - `o_cts = (remaining == 0) || (remaining == 1 && cycle == 0)`. This is the final clock of the last stop bit.
- `i_req` while `o_cts` is low: ignored and not latched; the source must hold `i_req`/`i_data` until accepted.
- `i_data` changes outside accept cycles have no effect.
- State summary:
  - IDLE: `remaining == 0`.
  - BUSY: `remaining > 1`, or `remaining == 1 && cycle > 0`.
  - LAST: the final stop-bit clock. `o_cts` is high; accepting here moves directly to a new frame.

## Timing
- Reset values (held while `rst_n` is low, applied asynchronously): `shift` all 1s, `remaining` 0, `cycle` 0. Therefore `o_serial = 1`, `o_cts = 1`, `o_idle = 1`.
- Reset mid-frame: the line returns high immediately and the partial frame is abandoned. The first accept after reset release sends a complete frame.
- Latency: accept on edge N; the start bit appears on `o_serial` after edge N and lasts exactly `clocks_per_bit` cycles. Every bit lasts exactly `clocks_per_bit` cycles.
- Frame duration is `frame_bits*clocks_per_bit` cycles.
- With `i_req` held continuously, frames are gapless: the next start bit begins on the cycle after the last stop-bit cycle.
  - `o_idle` stays low across back-to-back frames.
  - `o_cts` is high for exactly one cycle per frame.
- Unaccepted request from idle: `o_idle` stays high indefinitely. The first accept makes `o_idle` fall on the following cycle.
- Wrap-around: counters never wrap. `remaining` saturates at 0 and `cycle` is reloaded, never decremented below 0.

## Structure
- Shared package `uart_pkg`:
  - `uart_data_bits = 8`
  - `uart_start_bit = 1'b0`
  - `uart_stop_bit = 1'b1`
  - `uart_base_frame_bits = 10`
- The companion receiver uses the same package constants.
- Single module with no sub-module. The bit-period countdown is small enough to stay inline.

## Test plan
- Reset asserted mid-simulation → `o_serial = 1`, `o_cts = 1`, `o_idle = 1` with no clock edge required.
- `clocks_per_bit = 4`, `extra_stop_bits = 1`, send 0x55 → line 0,1,0,1,0,1,0,1,0,1,1, each level 4 cycles; 44 cycles total; `o_idle` high on cycle 45.
- `i_req` held with 0x48 then 0x69 (`clocks_per_bit = 4`, `extra_stop_bits = 0`) → second start bit immediately follows the first stop bit; `o_idle` low for 80 consecutive cycles; exactly two single-cycle `o_cts` accept pulses.
- Mid-frame, drive `i_req = 1` with `i_data = 0xFF` while `o_cts` is low → current frame unchanged; 0xFF is not sent unless `i_req` is still held at the next `o_cts`.
- Pull `rst_n` low during data bit 3 of 0xA5 → `o_serial` goes to 1 in the same cycle. After release, sending 0x3C yields a full 10-bit frame: 0,0,0,1,1,1,1,0,0,1.
- `clocks_per_bit = 3`, `extra_stop_bits = 0`, send 0x00 → 27 low cycles, then 3 high cycles; `o_cts` high only on cycle 30.
